// File: rtl/tlb_multiport_pkg.sv
// Shared TLB types: entry/result layouts, CP0 TLB opcodes and index width.
package tlb_multiport_pkg;

   localparam int TLB_ENTRIES = 32;
   localparam int TLB_IDXW    = $clog2(TLB_ENTRIES);
   localparam int TLB_WHICHW  = 6;

   typedef logic [TLB_IDXW-1:0] tlb_index_t;

   typedef enum logic [1:0] {
      TLBOP_TLBP  = 2'd0,
      TLBOP_TLBR  = 2'd1,
      TLBOP_TLBWI = 2'd2,
      TLBOP_TLBWR = 2'd3
   } tlbop_e;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
   } tlb_key_t;

   typedef struct packed {
      logic [31:0]           phy_addr;
      logic [TLB_WHICHW-1:0] which;
      logic                  miss;
      logic                  dirty;
      logic                  valid;
      logic [2:0]            cache_flag;
   } tlb_result_t;

   function automatic tlb_key_t tlb_key_of(input tlb_entry_t e);
      tlb_key_t k;
      k.vpn2 = e.vpn2;
      k.asid = e.asid;
      k.g    = e.g;
      return k;
   endfunction

endpackage

// File: rtl/tlb_multiport_if.sv
// Lookup ports and CP0 TLB-op bus between the MMU front-ends/CP0 and the TLB.
interface tlb_multiport_if
   import tlb_multiport_pkg::*;
#(
   parameter int PORTS = 2,
   parameter int IDXW  = 5
);
   logic [PORTS-1:0]        lk_req;
   logic [PORTS-1:0][19:0]  lk_vpn;
   logic [7:0]              asid;
   tlb_result_t [PORTS-1:0] lk_res;
   logic [PORTS-1:0]        lk_vld;

   logic                    op_req;
   tlbop_e                  op_code;
   logic [IDXW-1:0]         op_index;
   tlb_entry_t              op_wdata;
   logic [31:0]             op_entryhi;
   logic                    op_done;
   tlb_entry_t              op_rdata;
   logic [31:0]             op_probe;
   logic [IDXW-1:0]         random;

   modport master (
      output lk_req, lk_vpn, asid, op_req, op_code, op_index, op_wdata, op_entryhi,
      input  lk_res, lk_vld, op_done, op_rdata, op_probe, random
   );

   modport slave (
      input  lk_req, lk_vpn, asid, op_req, op_code, op_index, op_wdata, op_entryhi,
      output lk_res, lk_vld, op_done, op_rdata, op_probe, random
   );
endinterface

// File: rtl/tlb_match.sv
// Combinational VPN2/ASID compare over all entries; lowest matching index wins.
module tlb_match
   import tlb_multiport_pkg::*;
#(
   parameter int ENTRIES = 32,
   parameter int IDXW    = $clog2(ENTRIES)
) (
   input  tlb_key_t [ENTRIES-1:0] keys_i,
   input  logic [18:0]            vpn2_i,
   input  logic [7:0]             asid_i,
   output logic                   hit_o,
   output logic [IDXW-1:0]        idx_o
);

   logic [ENTRIES-1:0] match_s;

   always_comb begin
      match_s = '0;
      idx_o   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         match_s[i] = (keys_i[i].vpn2 == vpn2_i) && (keys_i[i].g || (keys_i[i].asid == asid_i));
      end
      // Scan downwards so the lowest matching index is the last one written.
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         idx_o = match_s[i] ? IDXW'(i) : idx_o;
      end
      hit_o = |match_s;
   end

endmodule

// File: rtl/tlb_multiport.sv
// Multi-port fully-associative MIPS TLB with CP0 TLBP/TLBR/TLBWI/TLBWR and Random.
// Optional TLB_WIRED_EN adds wired/wired_we and makes Random's lower bound CP0 Wired.
module tlb_multiport
   import tlb_multiport_pkg::*;
#(
   parameter int ENTRIES = 32,
   parameter int PORTS   = 2,
   parameter int IDXW    = $clog2(ENTRIES)
) (
   input  logic            clk,
   input  logic            reset,
`ifdef TLB_WIRED_EN
   input  logic [IDXW-1:0] wired,
   input  logic            wired_we,
`endif
   tlb_multiport_if.slave  bus
);

   localparam logic [IDXW-1:0] RAND_TOP = IDXW'(ENTRIES - 1);

   tlb_entry_t  [ENTRIES-1:0]  entries_q;
   tlb_key_t    [ENTRIES-1:0]  keys_s;
   tlb_result_t [PORTS-1:0]    lk_res_q;
   tlb_result_t [PORTS-1:0]    lk_res_d;
   logic        [PORTS-1:0]    lk_vld_q;
   logic        [PORTS-1:0]    lk_hit_s;
   logic [PORTS-1:0][IDXW-1:0] lk_idx_s;
   logic                       tlbp_hit_s;
   logic [IDXW-1:0]            tlbp_idx_s;
   logic [IDXW-1:0]            random_q;
   logic [IDXW-1:0]            random_d;
   logic                       op_done_q;
   logic [31:0]                probe_q;
   tlb_entry_t                 rdata_q;
   logic                       unused_s;

   assign unused_s = ^bus.op_entryhi[12:8];

   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         keys_s[i] = tlb_key_of(entries_q[i]);
      end
   end

   for (genvar p = 0; p < PORTS; p++) begin : g_lookup
      tlb_match #(.ENTRIES(ENTRIES), .IDXW(IDXW)) u_match (
         .keys_i (keys_s),
         .vpn2_i (bus.lk_vpn[p][19:1]),
         .asid_i (bus.asid),
         .hit_o  (lk_hit_s[p]),
         .idx_o  (lk_idx_s[p])
      );
   end

   tlb_match #(.ENTRIES(ENTRIES), .IDXW(IDXW)) u_probe (
      .keys_i (keys_s),
      .vpn2_i (bus.op_entryhi[31:13]),
      .asid_i (bus.op_entryhi[7:0]),
      .hit_o  (tlbp_hit_s),
      .idx_o  (tlbp_idx_s)
   );

   // vpn[0] picks the even or odd page of the matching pair.
   always_comb begin
      lk_res_d = '0;
      for (int p = 0; p < PORTS; p++) begin
         if (lk_hit_s[p]) begin
            lk_res_d[p].which = TLB_WHICHW'(lk_idx_s[p]);
            if (bus.lk_vpn[p][0]) begin
               lk_res_d[p].phy_addr   = {entries_q[lk_idx_s[p]].pfn1, 12'h000};
               lk_res_d[p].dirty      = entries_q[lk_idx_s[p]].d1;
               lk_res_d[p].valid      = entries_q[lk_idx_s[p]].v1;
               lk_res_d[p].cache_flag = entries_q[lk_idx_s[p]].c1;
            end else begin
               lk_res_d[p].phy_addr   = {entries_q[lk_idx_s[p]].pfn0, 12'h000};
               lk_res_d[p].dirty      = entries_q[lk_idx_s[p]].d0;
               lk_res_d[p].valid      = entries_q[lk_idx_s[p]].v0;
               lk_res_d[p].cache_flag = entries_q[lk_idx_s[p]].c0;
            end
         end else begin
            lk_res_d[p].miss = 1'b1;
         end
      end
   end

   always_comb begin
      random_d = random_q - IDXW'(1);
`ifdef TLB_WIRED_EN
      if (wired_we) begin
         random_d = RAND_TOP;
      end else if (random_q <= wired) begin
         random_d = RAND_TOP;
      end else begin
         random_d = random_q - IDXW'(1);
      end
`else
      if (random_q == '0) begin
         random_d = RAND_TOP;
      end else begin
         random_d = random_q - IDXW'(1);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lk_vld_q <= '0;
         lk_res_q <= '0;
         random_q <= RAND_TOP;
      end else begin
         lk_vld_q <= bus.lk_req;
         random_q <= random_d;
         for (int p = 0; p < PORTS; p++) begin
            if (bus.lk_req[p]) begin
               lk_res_q[p] <= lk_res_d[p];
            end
         end
      end
   end

   // TLBWR targets the Random value current in the op_req cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         entries_q <= '0;
         op_done_q <= 1'b0;
         probe_q   <= '0;
         rdata_q   <= '0;
      end else begin
         op_done_q <= bus.op_req;
         if (bus.op_req) begin
            case (bus.op_code)
               TLBOP_TLBP:  probe_q <= tlbp_hit_s ? 32'(tlbp_idx_s) : 32'h8000_0000;
               TLBOP_TLBR:  rdata_q <= entries_q[bus.op_index];
               TLBOP_TLBWI: entries_q[bus.op_index] <= bus.op_wdata;
               TLBOP_TLBWR: entries_q[random_q] <= bus.op_wdata;
               default:     probe_q <= probe_q;
            endcase
         end
      end
   end

   assign bus.lk_res   = lk_res_q;
   assign bus.lk_vld   = lk_vld_q;
   assign bus.op_done  = op_done_q;
   assign bus.op_probe = probe_q;
   assign bus.op_rdata = rdata_q;
   assign bus.random   = random_q;

endmodule

// File: tb/tb_tlb_multiport.sv
// Scoreboard bench for tlb_multiport: directed plan items plus randomized traffic vs a reference model.
module tb_tlb_multiport;
   import tlb_multiport_pkg::*;

   localparam int ENTRIES = 32;
   localparam int PORTS   = 2;
   localparam int IDXW    = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [IDXW-1:0] wired_s = '0;
   logic wired_we_s = 1'b0;

   always #5 clk = ~clk;

   tlb_multiport_if #(.PORTS(PORTS), .IDXW(IDXW)) bus ();

   tlb_multiport #(.ENTRIES(ENTRIES), .PORTS(PORTS)) dut (
      .clk      (clk),
      .reset    (reset),
`ifdef TLB_WIRED_EN
      .wired    (wired_s),
      .wired_we (wired_we_s),
`endif
      .bus      (bus)
   );

   typedef struct {int cyc; tlb_result_t res;} lk_item_t;
   typedef struct {int cyc; tlbop_e code; logic [31:0] probe; tlb_entry_t rdata;} op_item_t;

   tlb_entry_t model [ENTRIES];
   lk_item_t   q0[$];
   lk_item_t   q1[$];
   op_item_t   qop[$];
   int cyc = 0;
   int rnd_n = 0;
   int w_model = 0;
   int last_wr_idx = 0;
   int n_checks = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Random walks down from ENTRIES-1 to the lower bound, then wraps.
   function automatic int exp_random();
      int span;
      span = (w_model >= ENTRIES - 1) ? 1 : ENTRIES - w_model;
      return ENTRIES - 1 - (rnd_n % span);
   endfunction

   function automatic tlb_result_t ref_lookup(input logic [19:0] vpn, input logic [7:0] asid);
      tlb_result_t r;
      r = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (model[i].vpn2 == vpn[19:1] && (model[i].g || model[i].asid == asid)) begin
            r.which = TLB_WHICHW'(i);
            r.phy_addr = vpn[0] ? {model[i].pfn1, 12'h000} : {model[i].pfn0, 12'h000};
            r.dirty = vpn[0] ? model[i].d1 : model[i].d0;
            r.valid = vpn[0] ? model[i].v1 : model[i].v0;
            r.cache_flag = vpn[0] ? model[i].c1 : model[i].c0;
            return r;
         end
      end
      r.miss = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] ref_probe(input logic [31:0] ehi);
      for (int i = 0; i < ENTRIES; i++) begin
         if (model[i].vpn2 == ehi[31:13] && (model[i].g || model[i].asid == ehi[7:0])) return 32'(i);
      end
      return 32'h8000_0000;
   endfunction

   function automatic logic [18:0] pool_vpn2();
      case ($urandom_range(3, 0))
         0: return 19'h00010;
         1: return 19'h00123;
         2: return 19'h04444;
         default: return 19'h00777;
      endcase
   endfunction

   function automatic tlb_entry_t rand_entry();
      tlb_entry_t e;
      e.vpn2 = pool_vpn2();
      e.asid = 8'($urandom_range(3, 0));
      e.g    = 1'($urandom_range(1, 0));
      e.pfn0 = 20'($urandom);
      e.c0   = 3'($urandom);
      e.d0   = 1'($urandom);
      e.v0   = 1'($urandom);
      e.pfn1 = 20'($urandom);
      e.c1   = 3'($urandom);
      e.d1   = 1'($urandom);
      e.v1   = 1'($urandom);
      return e;
   endfunction

   task automatic look(input int p, input logic [19:0] vpn);
      bus.lk_req[p] = 1'b1;
      bus.lk_vpn[p] = vpn;
   endtask

   task automatic op(input tlbop_e c, input logic [IDXW-1:0] idx, input tlb_entry_t wd, input logic [31:0] ehi);
      bus.op_req     = 1'b1;
      bus.op_code    = c;
      bus.op_index   = idx;
      bus.op_wdata   = wd;
      bus.op_entryhi = ehi;
   endtask

   // Record expectations against pre-edge contents, then apply writes to the model.
   task automatic issue();
      lk_item_t li;
      op_item_t oi;
      if (bus.lk_req[0]) begin
         li.cyc = cyc; li.res = ref_lookup(bus.lk_vpn[0], bus.asid); q0.push_back(li);
      end
      if (bus.lk_req[1]) begin
         li.cyc = cyc; li.res = ref_lookup(bus.lk_vpn[1], bus.asid); q1.push_back(li);
      end
      if (bus.op_req) begin
         oi.cyc = cyc; oi.code = bus.op_code; oi.probe = '0; oi.rdata = '0;
         case (bus.op_code)
            TLBOP_TLBP:  oi.probe = ref_probe(bus.op_entryhi);
            TLBOP_TLBR:  oi.rdata = model[bus.op_index];
            TLBOP_TLBWI: model[bus.op_index] = bus.op_wdata;
            TLBOP_TLBWR: begin last_wr_idx = exp_random(); model[last_wr_idx] = bus.op_wdata; end
            default: ;
         endcase
         qop.push_back(oi);
      end
      @(posedge clk); #1;
      bus.lk_req = '0;
      bus.op_req = 1'b0;
      wired_we_s = 1'b0;
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         rnd_n <= 0; w_model <= 0;
      end else if (wired_we_s) begin
         rnd_n <= 0; w_model <= int'(wired_s);
      end else begin
         rnd_n <= rnd_n + 1;
      end
   end

   // Monitor: every output must appear exactly one cycle after its request.
   always @(negedge clk) begin
      if (mon_en) begin
         bit due0, due1, dueop;
         lk_item_t li;
         op_item_t oi;
         due0  = (q0.size() > 0) && (q0[0].cyc + 1 == cyc);
         due1  = (q1.size() > 0) && (q1[0].cyc + 1 == cyc);
         dueop = (qop.size() > 0) && (qop[0].cyc + 1 == cyc);
         chk("lk_vld_p0", bus.lk_vld[0], due0);
         chk("lk_vld_p1", bus.lk_vld[1], due1);
         if (due0) begin li = q0.pop_front(); if (bus.lk_vld[0]) chk("lk_res_p0", bus.lk_res[0], li.res); end
         if (due1) begin li = q1.pop_front(); if (bus.lk_vld[1]) chk("lk_res_p1", bus.lk_res[1], li.res); end
         chk("op_done", bus.op_done, dueop);
         if (dueop) begin
            oi = qop.pop_front();
            if (oi.code == TLBOP_TLBP) chk("op_probe", bus.op_probe, oi.probe);
            if (oi.code == TLBOP_TLBR) chk("op_rdata", bus.op_rdata, oi.rdata);
         end
         chk("random", bus.random, exp_random());
      end
   end

   initial begin
      tlb_entry_t e5, e2, e3, e9, e7, ew;
      bus.lk_req = '0; bus.lk_vpn = '0; bus.asid = '0;
      bus.op_req = 1'b0; bus.op_code = TLBOP_TLBP; bus.op_index = '0;
      bus.op_wdata = '0; bus.op_entryhi = '0;
      foreach (model[i]) model[i] = '0;
      @(posedge clk); #1; mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1; reset = 1'b0;
      @(negedge clk);
      chk("rst_lk_res", bus.lk_res, '0);
      chk("rst_probe", bus.op_probe, 32'h0);
      chk("rst_rdata", bus.op_rdata, '0);
      chk("rst_random", bus.random, 5'd31);

      e5 = '0; e5.vpn2 = 19'h00010; e5.asid = 8'h03; e5.pfn1 = 20'h1F000; e5.v1 = 1'b1; e5.d1 = 1'b1; e5.c1 = 3'd3;
      op(TLBOP_TLBWI, 5'd5, e5, 32'h0); issue();
      bus.asid = 8'h03; look(0, 20'h00021); look(1, 20'h00021); issue();
      @(negedge clk);
      chk("tp_phy", bus.lk_res[0].phy_addr, 32'h1F00_0000);
      chk("tp_which", bus.lk_res[0].which, 6'd5);
      chk("tp_dirty_cache", {bus.lk_res[0].dirty, bus.lk_res[0].cache_flag}, 4'b1011);
      chk("tp_same_p1", bus.lk_res[1].phy_addr, 32'h1F00_0000);
      bus.asid = 8'h04; look(0, 20'h00021); issue();
      @(negedge clk);
      chk("tp_asid_miss", {bus.lk_res[0].miss, bus.lk_res[0].phy_addr}, {1'b1, 32'h0});

      e2 = '0; e2.vpn2 = 19'h00123; e2.g = 1'b1; e2.pfn0 = 20'hABCDE; e2.v0 = 1'b1; e2.c0 = 3'd2;
      op(TLBOP_TLBWI, 5'd2, e2, 32'h0); look(0, {19'h00123, 1'b0}); issue();
      @(negedge clk);
      chk("wr_same_cycle_old", bus.lk_res[0].miss, 1'b1);
      look(0, {19'h00123, 1'b0}); issue();
      @(negedge clk);
      chk("wr_next_cycle_hit", {bus.lk_res[0].miss, bus.lk_res[0].which}, {1'b0, 6'd2});

      op(TLBOP_TLBP, 5'd0, '0, 32'h0002_0003); issue();
      @(negedge clk);
      chk("tlbp_hit", bus.op_probe, 32'd5);
      op(TLBOP_TLBP, 5'd0, '0, 32'h7FFF_E003); issue();
      @(negedge clk);
      chk("tlbp_miss", bus.op_probe, 32'h8000_0000);

      e9 = '0; e9.vpn2 = 19'h04444; e9.g = 1'b1; e9.pfn0 = 20'h09999; e9.v0 = 1'b1;
      e3 = e9; e3.pfn0 = 20'h03333;
      op(TLBOP_TLBWI, 5'd9, e9, 32'h0); issue();
      op(TLBOP_TLBWI, 5'd3, e3, 32'h0); issue();
      look(0, {19'h04444, 1'b0}); look(1, {19'h04444, 1'b0}); issue();
      @(negedge clk);
      chk("multi_hit_low", {bus.lk_res[1].which, bus.lk_res[1].phy_addr}, {6'd3, 32'h0333_3000});

      ew = rand_entry();
      op(TLBOP_TLBWR, 5'd0, ew, 32'h0); issue();
      op(TLBOP_TLBR, IDXW'(last_wr_idx), '0, 32'h0); issue();
      @(negedge clk);
      chk("tlbwr_readback", bus.op_rdata, ew);
      e7 = rand_entry();
      op(TLBOP_TLBWI, 5'd7, e7, 32'h0); issue();
      op(TLBOP_TLBR, 5'd7, '0, 32'h0); issue();
      @(negedge clk);
      chk("tlbwi_then_tlbr", bus.op_rdata, e7);

      for (int k = 0; k < 400; k++) begin
         bus.asid = 8'($urandom_range(3, 0));
         for (int p = 0; p < PORTS; p++) begin
            if ($urandom_range(1, 0) == 1) look(p, {pool_vpn2(), 1'($urandom_range(1, 0))});
         end
         if ($urandom_range(2, 0) != 0) begin
            op(tlbop_e'($urandom_range(3, 0)), IDXW'($urandom), rand_entry(),
               {pool_vpn2(), 5'($urandom), 8'($urandom_range(3, 0))});
         end
         issue();
      end

`ifdef TLB_WIRED_EN
      wired_s = 5'd4; wired_we_s = 1'b1; issue();
      repeat (64) issue();
      wired_s = 5'd31; wired_we_s = 1'b1; issue();
      repeat (5) issue();
      wired_s = 5'd30; wired_we_s = 1'b1; issue();
      repeat (5) issue();
      wired_s = 5'd0; wired_we_s = 1'b1; issue();
      repeat (3) issue();
`endif

      repeat (2) issue();
      op(TLBOP_TLBWI, 5'd1, e5, 32'h0); look(0, 20'h00021);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; bus.op_req = 1'b0; bus.lk_req = '0;
      foreach (model[i]) model[i] = '0;
      op(TLBOP_TLBR, 5'd1, '0, 32'h0); issue();
      @(negedge clk);
      chk("reset_drops_write", bus.op_rdata, '0);

      repeat (3) issue();
      chk("queues_drained", q0.size() + q1.size() + qop.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
